// File: rtl/axis_slave_fifo.sv
// AXI4-Stream receive buffer: DEPTH-entry first-word-fall-through FIFO with
// fill-level and packet counters. PACKET_MODE selects cut-through or store-and-forward.
//
// state  | meaning
// IDLE   | output withheld, waiting for the release condition
// STREAM | head entry presented on the master port
module axis_slave_fifo #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 16,
  parameter int PACKET_MODE = 0
) (
  input  logic                     s_axis_clk,
  input  logic                     s_axis_resetn,
  input  logic                     s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic                     s_axis_tlast,
  output logic                     s_axis_tready,
  output logic                     m_axis_tvalid,
  output logic [DATA_WIDTH-1:0]    m_axis_tdata,
  output logic                     m_axis_tlast,
  input  logic                     m_axis_tready,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic [15:0]              pkt_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, STREAM} state_t;

  logic [DATA_WIDTH:0] mem [DEPTH];
  logic [AW:0]         wr_ptr, rd_ptr, complete_pkts;
  logic [AW:0]         wr_ptr_nxt, rd_ptr_nxt, cpl_nxt, count_nxt;
  logic [DATA_WIDTH:0] head;
  logic                full, empty;
  logic                wr_en, rd_en, wr_last, rd_last;
  state_t              state;

  // A packet larger than the FIFO can never complete, so a full FIFO also
  // releases in store-and-forward mode.
  function automatic logic release_ok(input logic [AW:0] count, input logic [AW:0] cpl);
    if (count == '0) return 1'b0;
    if (PACKET_MODE == 0) return 1'b1;
    return (cpl != '0) || (count == DEPTH_L);
  endfunction

  assign empty         = (wr_ptr == rd_ptr);
  assign full          = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign head          = mem[rd_ptr[AW-1:0]];
  assign s_axis_tready = !full;
  assign m_axis_tvalid = (state == STREAM);
  assign m_axis_tdata  = head[DATA_WIDTH-1:0];
  assign m_axis_tlast  = head[DATA_WIDTH];
  assign fill_level    = wr_ptr - rd_ptr;

  assign wr_en   = s_axis_tvalid && !full;
  assign rd_en   = m_axis_tvalid && m_axis_tready;
  assign wr_last = wr_en && s_axis_tlast;
  assign rd_last = rd_en && head[DATA_WIDTH];

  always_comb begin
    wr_ptr_nxt = wr_en ? (wr_ptr + PTR_ONE) : wr_ptr;
    rd_ptr_nxt = rd_en ? (rd_ptr + PTR_ONE) : rd_ptr;
    count_nxt  = wr_ptr_nxt - rd_ptr_nxt;
    cpl_nxt    = complete_pkts;
    if (wr_last && !rd_last)
      cpl_nxt = complete_pkts + PTR_ONE;
    else if (!wr_last && rd_last)
      cpl_nxt = complete_pkts - PTR_ONE;
  end

  always_ff @(posedge s_axis_clk) begin
    if (wr_en)
      mem[wr_ptr[AW-1:0]] <= {s_axis_tlast, s_axis_tdata};
  end

  always_ff @(posedge s_axis_clk or negedge s_axis_resetn) begin
    if (!s_axis_resetn) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      complete_pkts <= '0;
      pkt_count     <= '0;
    end else begin
      wr_ptr        <= wr_ptr_nxt;
      rd_ptr        <= rd_ptr_nxt;
      complete_pkts <= cpl_nxt;
      if (wr_last)
        pkt_count <= pkt_count + 16'd1;
      case (state)
        IDLE: begin
          if (release_ok(fill_level, complete_pkts))
            state <= STREAM;
        end
        STREAM: begin
          // Mid-packet reads keep streaming; only an emptied FIFO or a packet
          // boundary without a further releasable packet drops tvalid.
          if (rd_en) begin
            if (count_nxt == '0)
              state <= IDLE;
            else if (rd_last && !release_ok(count_nxt, cpl_nxt))
              state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic unused_empty;
  assign unused_empty = empty;

endmodule
